// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Constants shared by the ALU compare path: the operand width
//                and the branch condition codes evaluated by comp_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operand width; compare datapath is one bit wider.
    localparam int W = 64;

    // Condition codes carried alongside each compare operation.
    localparam logic [1:0] COND_EQ = 2'd0;
    localparam logic [1:0] COND_NE = 2'd1;
    localparam logic [1:0] COND_LT = 2'd2;
    localparam logic [1:0] COND_GE = 2'd3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/comp_sign_extend.sv
`default_nettype none
// ============================================================================
//  Module      : comp_sign_extend
//  Description : Widens a W-bit operand to W+1 bits. With i_ext = 1 the MSB
//                is replicated (two's-complement); with i_ext = 0 a zero is
//                prepended (unsigned). Purely combinational.
//  Ports       : i_data [W-1:0] operand in
//                i_ext          1 = sign-extend, 0 = zero-extend
//                o_data [W:0]   extended operand
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_sign_extend #(
    parameter int W = 64
) (
    input  logic [W-1:0] i_data,
    input  logic         i_ext,
    output logic [W:0]   o_data
);

    assign o_data = {i_ext & i_data[W-1], i_data};

endmodule : comp_sign_extend
`default_nettype wire

// File: rtl/comp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : comp_pipe
//  Description : Two-stage pipelined compare unit. S1 registers the extended
//                operands and condition code; S2 subtracts in W+1 bits and
//                registers LT/EQ/GT plus the evaluated branch condition.
//                Valid/ready on both sides, one operation per cycle.
//  Ports       : clk, reset (async, active-high), flush (sync)
//                in_valid / in_ready   upstream handshake
//                a, b [W-1:0]          operands
//                is_signed             1 = signed compare, 0 = unsigned
//                cond [1:0]            EQ / NE / LT / GE
//                out_valid / out_ready downstream handshake
//                lt, eq, gt, taken     registered results
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_pipe #(
    parameter int W = alu_pkg::W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    input  logic [1:0]   cond,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         lt,
    output logic         eq,
    output logic         gt,
    output logic         taken
);

    import alu_pkg::*;

    // ------------------------------------------------------------------
    // Operand widening
    // ------------------------------------------------------------------
    logic [W:0] w_xa;
    logic [W:0] w_xb;

    comp_sign_extend #(.W(W)) u_ext_a (
        .i_data (a),
        .i_ext  (is_signed),
        .o_data (w_xa)
    );

    comp_sign_extend #(.W(W)) u_ext_b (
        .i_data (b),
        .i_ext  (is_signed),
        .o_data (w_xb)
    );

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic       r_s1_valid;
    logic [W:0] r_xa;
    logic [W:0] r_xb;
    logic [1:0] r_cond;

    logic       r_out_valid;
    logic       r_lt;
    logic       r_eq;
    logic       r_gt;
    logic       r_taken;

    // ------------------------------------------------------------------
    // Handshake: each stage may take new data when it is empty or when its
    // current contents leave this cycle.
    // ------------------------------------------------------------------
    logic w_s2_ready;
    logic w_s1_ready;
    logic w_load;
    logic w_adv;

    assign w_s2_ready = ~r_out_valid | out_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;
    assign w_load     = in_valid & w_s1_ready;
    assign w_adv      = r_s1_valid & w_s2_ready;

    // ------------------------------------------------------------------
    // Compare. Both extended operands fit in W+1-bit signed, and so does
    // their difference, so the top bit of the difference is the exact sign.
    // ------------------------------------------------------------------
    logic [W:0] w_diff;
    logic       w_lt;
    logic       w_eq;
    logic       w_gt;
    logic       w_taken;

    assign w_diff = r_xa - r_xb;
    assign w_lt   = w_diff[W];
    assign w_eq   = ~|w_diff;
    assign w_gt   = ~w_lt & ~w_eq;

    always_comb begin
        w_taken = 1'b0;
        case (r_cond)
            COND_EQ: w_taken = w_eq;
            COND_NE: w_taken = ~w_eq;
            COND_LT: w_taken = w_lt;
            COND_GE: w_taken = ~w_lt;
            default: w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage registers. Flush wins over any load or advance in its cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_xa        <= '0;
            r_xb        <= '0;
            r_cond      <= COND_EQ;
            r_out_valid <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_gt        <= 1'b0;
            r_taken     <= 1'b0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_load) begin
                r_xa   <= w_xa;
                r_xb   <= w_xb;
                r_cond <= cond;
            end
            if (w_s2_ready) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_adv) begin
                r_lt    <= w_lt;
                r_eq    <= w_eq;
                r_gt    <= w_gt;
                r_taken <= w_taken;
            end
        end
    end

    assign in_ready  = w_s1_ready;
    assign out_valid = r_out_valid;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign taken     = r_taken;

endmodule : comp_pipe
`default_nettype wire

// File: tb/tb_comp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comp_pipe
//  Description : Self-checking bench for comp_pipe. Expected flags come from
//                a behavioural compare model (native signed/unsigned compare)
//                and an in-order queue of accepted operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_pipe;

    localparam int TW = 64;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          is_signed;
    logic [1:0]    cond;
    logic          out_valid;
    logic          out_ready;
    logic          lt;
    logic          eq;
    logic          gt;
    logic          taken;

    logic [3:0]    flags;
    assign flags = {lt, eq, gt, taken};

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] q[$];

    comp_pipe #(.W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .taken     (taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: {lt, eq, gt, taken} from native comparisons.
    function automatic logic [3:0] model(input logic [TW-1:0] fa, input logic [TW-1:0] fb,
                                         input logic fs, input logic [1:0] fc);
        logic l, e, t;
        l = fs ? ($signed(fa) < $signed(fb)) : (fa < fb);
        e = (fa == fb);
        case (fc)
            2'd0:    t = e;
            2'd1:    t = !e;
            2'd2:    t = l;
            default: t = !l;
        endcase
        return {l, e, !l && !e, t};
    endfunction

    task automatic rand_op(output logic [TW-1:0] ra, output logic [TW-1:0] rb,
                           output logic rs, output logic [1:0] rc);
        ra = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ 64'h8000_0000_0000_0000;
            2:       rb = ra + 64'd1;
            default: rb = {$urandom, $urandom};
        endcase
        rs = 1'($urandom_range(0, 1));
        rc = 2'($urandom_range(0, 3));
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({out_valid, flags} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {out_valid, flags});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_directed;
        logic [TW-1:0] va [6];
        logic [TW-1:0] vb [6];
        logic          vs [6];
        logic [1:0]    vc [6];
        logic [3:0]    ve [6];
        va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
        vb = '{64'd1, 64'd1,
               64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
        vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vc = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
        ve = '{4'b1001, 4'b0010, 4'b1000, 4'b0011, 4'b0101, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            a = va[i]; b = vb[i]; is_signed = vs[i]; cond = vc[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_early[%0d]: out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || flags !== ve[i]) begin
                n_fail++;
                $display("FAIL directed[%0d]: valid=%b flags=%b want 1 %b", i, out_valid, flags, ve[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_throughput;
        int first_acc = -1;
        int first_ov  = -1;
        int last_ov   = -1;
        int n_ov      = 0;
        logic [3:0] exp;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 8) begin
                rand_op(a, b, is_signed, cond);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, is_signed, cond));
                if (first_acc < 0) first_acc = cyc;
            end
            if (out_valid) begin
                n_ov++;
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL thru_extra: unexpected result flags=%b", flags);
                end else begin
                    exp = q.pop_front();
                    if (flags !== exp) begin
                        n_fail++;
                        $display("FAIL thru_data: cyc %0d flags=%b want %b", cyc, flags, exp);
                    end
                end
            end
        end
        n_checks++;
        if (n_ov != 8 || last_ov - first_ov != 7 || first_ov != first_acc + 2) begin
            n_fail++;
            $display("FAIL thru_timing: n_ov=%0d first_ov=%0d last_ov=%0d first_acc=%0d want 8, span 7, +2",
                     n_ov, first_ov, last_ov, first_acc);
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL thru_lost: %0d results missing want 0", q.size());
        end
        q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure;
        logic [TW-1:0] oa [3];
        logic [TW-1:0] ob [3];
        logic          os [3];
        logic [1:0]    oc [3];
        logic [3:0]    snap;
        logic [3:0]    exp;
        int next    = 0;
        int drained = 0;
        snap = '0;
        for (int i = 0; i < 3; i++) rand_op(oa[i], ob[i], os[i], oc[i]);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            in_valid = (next < 3);
            if (next < 3) begin
                a = oa[next]; b = ob[next]; is_signed = os[next]; cond = oc[next];
            end
            @(negedge clk);
            if (cyc >= 2) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: cyc %0d got %b want 0", cyc, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, is_signed, cond));
                next++;
            end
            if (cyc == 2) snap = flags;
            if (cyc == 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || flags !== snap || flags !== q[0]) begin
                    n_fail++;
                    $display("FAIL bp_stall: valid=%b flags=%b snap=%b want %b", out_valid, flags, snap, q[0]);
                end
                n_checks++;
                if (next != 2) begin
                    n_fail++;
                    $display("FAIL bp_accepted: got %0d want 2", next);
                end
            end
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = (next < 3);
            if (next < 3) begin
                a = oa[next]; b = ob[next]; is_signed = os[next]; cond = oc[next];
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, is_signed, cond));
                next++;
            end
            if (out_valid && out_ready) begin
                drained++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_dup: extra result flags=%b", flags);
                end else begin
                    exp = q.pop_front();
                    if (flags !== exp) begin
                        n_fail++;
                        $display("FAIL bp_order: flags=%b want %b", flags, exp);
                    end
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (drained != 3 || q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: drained=%0d left=%0d want 3/0", drained, q.size());
        end
        q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush;
        int n_ov;
        logic [3:0] exp;
        // Both stages full, downstream stalled.
        out_ready = 1'b0;
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond); in_valid = 1'b1;
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond);
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond); flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre: valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_out_valid: got %b want 0", out_valid);
        end
        out_ready = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        n_checks++;
        if (n_ov != 0) begin
            n_fail++;
            $display("FAIL flush_ghost: %0d results after flush want 0", n_ov);
        end
        // Flush with an accepting pipe: the concurrent input must be dropped.
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond); in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_ov = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        n_checks++;
        if (n_ov != 0) begin
            n_fail++;
            $display("FAIL flush_priority: %0d results want 0", n_ov);
        end
        // Pipeline still usable.
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond); in_valid = 1'b1;
        exp = model(a, b, is_signed, cond);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || flags !== exp) begin
            n_fail++;
            $display("FAIL flush_recover: valid=%b flags=%b want 1 %b", out_valid, flags, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midstream;
        logic [3:0] exp;
        int n_ov;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond); in_valid = 1'b1;
        exp = model(a, b, is_signed, cond);
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || flags !== exp) begin
            n_fail++;
            $display("FAIL rst_pre: valid=%b flags=%b want 1 %b", out_valid, flags, exp);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, flags} !== 5'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: outs=%b in_ready=%b want 00000/1", {out_valid, flags}, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        n_ov = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) n_ov++;
        end
        n_checks++;
        if (n_ov != 0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_discard: %0d stale results in_ready=%b want 0/1", n_ov, in_ready);
        end
        @(posedge clk); #1;
        rand_op(a, b, is_signed, cond); in_valid = 1'b1;
        exp = model(a, b, is_signed, cond);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_latency_early: valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || flags !== exp) begin
            n_fail++;
            $display("FAIL rst_latency: valid=%b flags=%b want 1 %b", out_valid, flags, exp);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random;
        logic [3:0] exp;
        for (int cyc = 0; cyc < 306; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 300) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                rand_op(a, b, is_signed, cond);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready) q.push_back(model(a, b, is_signed, cond));
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: cyc %0d flags=%b", cyc, flags);
                end else begin
                    exp = q.pop_front();
                    if (flags !== exp) begin
                        n_fail++;
                        $display("FAIL rand_data: cyc %0d flags=%b want %b", cyc, flags, exp);
                    end
                end
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_lost: %0d results missing want 0", q.size());
        end
        q.delete();
    endtask

    // ------------------------------------------------------------------
    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        cond      = 2'd0;

        test_reset();
        test_directed();
        test_throughput();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_comp_pipe
`default_nettype wire
